// File: rtl/rescueprime_pkg.sv
// Shared encodings and size helpers for the Rescue-Prime drain serializer.
package rescueprime_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  function automatic int bytes_per_elem(input int n_bits);
    return (n_bits + 7) / 8;
  endfunction

  function automatic int total_bytes(input int n_bits);
    return 3 * bytes_per_elem(n_bits);
  endfunction

  // Never returns less than 1 so a one-byte frame still gets a counter bit.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rescueprime_state_serializer.sv
// Captures the three permutation output elements and streams them LSB byte
// first (elem_1, elem_2, elem_3) over a valid/ready byte interface.
module rescueprime_state_serializer
  import rescueprime_pkg::*;
#(
  parameter int N_BITS = 254
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [N_BITS-1:0] elem_1,
  input  logic [N_BITS-1:0] elem_2,
  input  logic [N_BITS-1:0] elem_3,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic              busy,
  output logic              overrun,
  input  logic              overrun_clr
);

  localparam int BYTES_PER_ELEM = bytes_per_elem(N_BITS);
  localparam int TOTAL_BYTES    = total_bytes(N_BITS);
  localparam int CNT_W          = clog2_min1(TOTAL_BYTES);
  localparam int ELEM_W         = BYTES_PER_ELEM * 8;
  localparam int SR_W           = TOTAL_BYTES * 8;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL_BYTES - 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [SR_W-1:0]  sr;
  logic             sending;
  logic             at_last;
  logic             last_hs;
  logic             capture;
  logic             drop;

  assign sending = (state == ST_SEND);
  assign at_last = (cnt == LAST_CNT);
  assign last_hs = sending && tx_ready && at_last;
  // A strobe is only accepted when no frame would be cut short by it.
  assign capture = in_valid && (!sending || last_hs);
  assign drop    = in_valid && sending && !last_hs;

  assign tx_data  = sr[7:0];
  assign tx_valid = sending;
  assign busy     = sending;
  assign tx_last  = sending && at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      sr    <= '0;
    end else if (capture) begin
      state <= ST_SEND;
      cnt   <= '0;
      sr    <= {ELEM_W'(elem_3), ELEM_W'(elem_2), ELEM_W'(elem_1)};
    end else if (sending && tx_ready) begin
      sr <= sr >> 8;
      if (at_last) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Set takes priority over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rescueprime_state_serializer.sv
// Scoreboard bench for the Rescue-Prime drain serializer (254-bit and 4-bit builds).
module tb_rescueprime_state_serializer;

  localparam int BPE = 32;
  localparam int TOT = 96;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         tx_ready = 1'b0;
  logic         overrun_clr = 1'b0;
  logic [253:0] elem_1 = '0;
  logic [253:0] elem_2 = '0;
  logic [253:0] elem_3 = '0;
  logic [7:0]   tx_data;
  logic         tx_valid, tx_last, busy, overrun;

  logic         s_in_valid = 1'b0;
  logic [3:0]   s_e1 = '0, s_e2 = '0, s_e3 = '0;
  logic [7:0]   s_tx_data;
  logic         s_tx_valid, s_tx_last, s_busy, s_overrun;

  rescueprime_state_serializer #(.N_BITS(254)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .elem_1(elem_1), .elem_2(elem_2), .elem_3(elem_3),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_last(tx_last), .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  rescueprime_state_serializer #(.N_BITS(4)) s_dut (
    .clk(clk), .rst(rst), .in_valid(s_in_valid),
    .elem_1(s_e1), .elem_2(s_e2), .elem_3(s_e3),
    .tx_data(s_tx_data), .tx_valid(s_tx_valid), .tx_ready(1'b1),
    .tx_last(s_tx_last), .busy(s_busy), .overrun(s_overrun), .overrun_clr(1'b0)
  );

  // Expected bytes {last, data}; the monitor only advances read indices.
  logic [8:0] q[$];
  logic [8:0] sq[$];
  int   rd_idx = 0;
  int   srd_idx = 0;
  int   mdl_left = 0;
  logic mdl_ovr = 1'b0;
  logic tmo = 1'b0;
  logic done = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic void push_frame(input logic [253:0] a, input logic [253:0] b,
                                     input logic [253:0] c);
    logic [253:0] el[3];
    el[0] = a; el[1] = b; el[2] = c;
    for (int e = 0; e < 3; e++)
      for (int k = 0; k < BPE; k++)
        q.push_back({(e == 2 && k == BPE - 1), 8'(el[e] >> (8 * k))});
  endfunction

  function automatic logic [253:0] rnd254();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[32*i +: 32] = $urandom;
    return t[253:0];
  endfunction

  function automatic logic [253:0] fill254(input logic [7:0] b);
    logic [255:0] t;
    for (int i = 0; i < 32; i++) t[8*i +: 8] = b;
    return t[253:0];
  endfunction

  // Model: bytes remaining in the frame; a strobe is taken only when nothing
  // is left or the single remaining byte is handed over in the same cycle.
  task automatic step(input logic iv, input logic rdy, input logic clr);
    logic acc;
    in_valid = iv; tx_ready = rdy; overrun_clr = clr;
    @(posedge clk);
    if (!rst) begin
      acc = iv && (mdl_left == 0 || (mdl_left == 1 && rdy));
      if (iv && !acc) mdl_ovr = 1'b1;
      else if (clr) mdl_ovr = 1'b0;
      if (mdl_left > 0 && rdy) mdl_left--;
      if (acc) begin
        mdl_left = TOT;
        push_frame(elem_1, elem_2, elem_3);
      end
      if (s_in_valid)
        for (int e = 0; e < 3; e++)
          sq.push_back({(e == 2), 4'h0, (e == 0) ? s_e1 : (e == 1) ? s_e2 : s_e3});
    end
    #1;
  endtask

  task automatic run_out(input bit rand_ready);
    for (int n = 0; n < 2000 && mdl_left != 0; n++)
      step(1'b0, rand_ready ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
    if (mdl_left != 0) tmo = 1'b1;
    repeat (2) step(1'b0, 1'b1, 1'b0);
  endtask

  always @(negedge clk) begin : monitor
    logic       exp_v, s_exp_v;
    logic [8:0] e;
    logic       stall_p;
    logic [7:0] stall_d;
    logic       stall_l;
    if (rst) begin
      rd_idx  = q.size();
      srd_idx = sq.size();
      stall_p = 1'b0;
      check("rst_data", tx_data, 0);
      check("rst_last", tx_last, 0);
      check("s_rst_data", s_tx_data, 0);
    end
    exp_v = rd_idx < q.size();
    check("valid", tx_valid, exp_v);
    check("busy", busy, exp_v);
    check("overrun", overrun, mdl_ovr);
    check("timeout", tmo, 0);
    if (stall_p) begin
      check("stall_data", tx_data, stall_d);
      check("stall_last", tx_last, stall_l);
    end
    if (exp_v && tx_valid) begin
      e = q[rd_idx];
      check("byte", tx_data, e[7:0]);
      check("last", tx_last, e[8]);
      if (tx_ready) rd_idx++;
    end
    stall_p = tx_valid && !tx_ready && !rst;
    stall_d = tx_data;
    stall_l = tx_last;

    s_exp_v = srd_idx < sq.size();
    check("s_valid", s_tx_valid, s_exp_v);
    check("s_busy", s_busy, s_exp_v);
    check("s_overrun", s_overrun, 0);
    if (s_exp_v && s_tx_valid) begin
      e = sq[srd_idx];
      check("s_byte", s_tx_data, e[7:0]);
      check("s_last", s_tx_last, e[8]);
      srd_idx++;
    end

    if (done) begin
      check("drained", rd_idx, q.size());
      check("s_drained", srd_idx, sq.size());
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    logic [255:0] pat;
    #1 rst = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b0);

    // basic frame
    elem_1 = 254'd1; elem_2 = 254'd2; elem_3 = 254'd3;
    step(1'b1, 1'b1, 1'b0);
    run_out(1'b0);

    // backpressure with 0x0102..20 pattern
    for (int i = 0; i < 32; i++) pat[8*i +: 8] = 8'(32 - i);
    elem_1 = pat[253:0]; elem_2 = rnd254(); elem_3 = rnd254();
    step(1'b1, 1'b1, 1'b0);
    run_out(1'b1);

    // overrun at byte 10
    elem_1 = fill254(8'hAA); elem_2 = fill254(8'hFF); elem_3 = rnd254();
    step(1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 200 && mdl_left > TOT - 10; n++) step(1'b0, 1'b1, 1'b0);
    elem_1 = fill254(8'h55);
    step(1'b1, 1'b1, 1'b0);
    run_out(1'b0);
    repeat (5) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);

    // overrun and clear in the same cycle
    elem_1 = rnd254(); elem_2 = rnd254(); elem_3 = rnd254();
    step(1'b1, 1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    run_out(1'b0);
    step(1'b0, 1'b1, 1'b1);

    // back-to-back frames
    elem_1 = rnd254(); elem_2 = rnd254(); elem_3 = rnd254();
    step(1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 200 && mdl_left > 1; n++) step(1'b0, 1'b1, 1'b0);
    elem_1 = rnd254(); elem_2 = rnd254(); elem_3 = rnd254();
    step(1'b1, 1'b1, 1'b0);
    run_out(1'b0);

    // reset mid-frame, then restart with elem_1 = 7
    elem_1 = rnd254(); elem_2 = rnd254(); elem_3 = rnd254();
    step(1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 200 && mdl_left > TOT - 40; n++) step(1'b0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    mdl_left = 0; mdl_ovr = 1'b0;
    repeat (2) step(1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    elem_1 = 254'd7; elem_2 = rnd254(); elem_3 = rnd254();
    step(1'b1, 1'b1, 1'b0);
    run_out(1'b0);

    // randomized frames with stray strobes, stalls and clears
    for (int f = 0; f < 8; f++) begin
      elem_1 = rnd254(); elem_2 = rnd254(); elem_3 = rnd254();
      step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      for (int n = 0; n < 1500 && mdl_left != 0; n++) begin
        if ($urandom_range(0, 9) == 0) elem_1 = rnd254();
        step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 29) == 0));
      end
      if (mdl_left != 0) tmo = 1'b1;
      step(1'b0, 1'b1, 1'b1);
    end

    // 4-bit build: three one-byte elements
    s_e1 = 4'hF; s_e2 = 4'h9; s_e3 = 4'h1;
    s_in_valid = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    s_in_valid = 1'b0;
    repeat (6) step(1'b0, 1'b1, 1'b0);

    done = 1'b1;
    #40;
    $display("FAIL end_of_run: monitor did not finish");
    $fatal(1);
  end

endmodule

// File: doc/rescueprime_state_serializer.md
Name: rescueprime_state_serializer

Overview:
- Drain end of the Rescue-Prime permutation datapath.
- Captures the three N_BITS output elements when the permutation's ready strobe fires, then streams them out as bytes over a valid/ready interface. The stream feeds a board-level UART/AXI-Stream bridge.
- Replaces the LED OR-reduction, so every result bit is observable off-chip.

Parameters:
- N_BITS, 254, width of one field element.
- BYTES_PER_ELEM, (N_BITS+7)/8, bytes per element; derived, not overridden.
- TOTAL_BYTES, 3*BYTES_PER_ELEM, bytes per frame; 96 at the default.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  single-cycle capture strobe; connects to the permutation ready.
- elem_1  in  N_BITS  permutation output element 1.
- elem_2  in  N_BITS  permutation output element 2.
- elem_3  in  N_BITS  permutation output element 3.
- tx_data  out  8  current output byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  downstream accepts the byte; a handshake occurs when tx_valid && tx_ready.
- tx_last  out  1  high with the final byte of a frame.
- busy  out  1  a frame is held or being sent.
- overrun  out  1  sticky flag: a capture strobe was dropped.
- overrun_clr  in  1  synchronous clear for overrun.

Behaviour:
- Reset values (asynchronous assert): state IDLE, tx_valid=0, tx_last=0, busy=0, overrun=0, tx_data=0, byte counter=0, shift register=0.
- States:
  - IDLE: tx_valid=0, busy=0.
  - SEND: tx_valid=1, busy=1.
- Capture, IDLE to SEND:
  - Condition: in_valid=1 while in IDLE.
  - Load the shift register with {pad3,elem_3,pad2,elem_2,pad1,elem_1}. Each element is zero-extended to BYTES_PER_ELEM*8 bits.
  - tx_valid rises on the next cycle, so latency from in_valid to the first byte is 1 cycle.
- Byte order:
  - elem_1 first, then elem_2, then elem_3.
  - Within an element, least-significant byte first.
  - tx_data always equals shift register bits [7:0].
- Handshake in SEND:
  - On each handshake, shift the register right by 8 and increment the counter.
  - Without a handshake, tx_data, tx_valid and tx_last hold stable; tx_valid never drops mid-frame.
  - tx_last = tx_valid && (counter == TOTAL_BYTES-1).
- End of frame:
  - A handshake on the last byte with in_valid=0 returns to IDLE; the counter returns to 0.
- Back-to-back frames:
  - in_valid=1 in the same cycle as the last-byte handshake captures the new frame.
  - State stays SEND and the counter resets to 0, giving zero bubble between frames.
- Overrun:
  - in_valid=1 in SEND, other than the last-byte-handshake cycle, sets overrun. The new data is discarded and the current frame continues unaltered.
  - overrun_clr clears the flag.
  - overrun_clr and a new overrun event in the same cycle: set wins.
- Reset mid-frame: state returns to IDLE immediately (asynchronous) and the frame is abandoned; no partial resume after reset release.
- Width rules:
  - Counter width is clog2(TOTAL_BYTES), minimum 1.
  - Pad bits are always 0, so with N_BITS=254 bits 6..7 of each element's top byte are 0.

Decomposition:
- rescueprime_pkg holds the state encoding (IDLE/SEND), the BYTES_PER_ELEM and TOTAL_BYTES derivation functions, and a clog2 helper.
- Single module with no sub-module. The shift register, counter and two-state FSM fit in about 150 lines.

Test Plan:
- Basic frame:
  - Stimulus: N_BITS=254, elem_1=1, elem_2=2, elem_3=3, in_valid pulse, tx_ready held 1.
  - Required: 96 bytes on consecutive cycles starting 1 cycle after the strobe. Byte0=0x01, byte32=0x02, byte64=0x03, all other bytes 0x00. tx_last only on byte 95. busy falls after byte 95.
- Backpressure:
  - Stimulus: elem_1=0x0102…20 pattern, tx_ready toggling 1/0 pseudo-randomly.
  - Required: tx_data, tx_valid and tx_last stable during every stall cycle. Byte sequence identical to the tx_ready=1 run. Frame completes only after 96 handshakes.
- Overrun:
  - Stimulus: in_valid pulse at byte 10 of a frame with elem_1=0xAA.., second strobe with elem_1=0x55...
  - Required: frame continues with the 0xAA data. overrun=1 and stays 1 until overrun_clr. No second frame is emitted.
- Back-to-back:
  - Stimulus: second in_valid coincident with the byte-95 handshake.
  - Required: the next cycle shows byte0 of frame 2, tx_valid continuously high, overrun remains 0.
- Reset mid-frame:
  - Stimulus: assert rst at byte 40, release, then new in_valid with elem_1=7.
  - Required: tx_valid=0 and busy=0 immediately on assert. After the new strobe, the first byte is 0x07 and the counter restarts at 0.
- Small width:
  - Stimulus: N_BITS=4, elems 0xF, 0x9, 0x1.
  - Required: TOTAL_BYTES=3, bytes 0x0F, 0x09, 0x01, tx_last on the third byte.
